phaser_gen: RTL and testbench
=============================

PHASER_GEN -- requirements
Module: phaser_gen

Interface
REQ-001 Parameter NMC, default 6: microcycles per CPU cycle; legal range 4..16.
REQ-002 Parameter NLOW, default 3: microcycles with cphi2 low; legal range 2..NMC-2.
REQ-003 Parameter VSHIFT, default 1: vphi2 lag behind cphi2, in microcycles; legal range 0..NLOW-1.
REQ-004 Parameter MAXWAIT, default 15: maximum stretch microcycles per CPU cycle; legal range 1..255.
REQ-005 Parameter CCW, default 16: width of the CPU cycle counter.
REQ-006 clk6x  in  1  system clock, NMC times the CPU clock; one clock; reset is synchronous and active-high.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 run  in  1  allows the CPU to run.
REQ-009 stretch  in  1  wait-state request that extends the cphi2-high phase.
REQ-010 stopped  out  1  CPU is halted in the safe low phase.
REQ-011 cphi2  out  1  generated 65C02 PHI2.
REQ-012 vphi2  out  1  generated 65C22 PHI2, lagging cphi2 by VSHIFT microcycles.
REQ-013 setup_cs  out  1  one-microcycle pulse: capture the CPU address and set up the CSx signals.
REQ-014 release_wr  out  1  one-microcycle pulse: release the MWR signals.
REQ-015 release_cs  out  1  one-microcycle pulse: CPU access is complete, release CS.
REQ-016 stretch_to  out  1  one-microcycle pulse: stretch was forcibly ended at MAXWAIT.
REQ-017 cycle_cnt  out  CCW  count of completed CPU cycles.

Function
REQ-018 A phase counter ph SHALL count 0..NMC-1 and wrap to 0; all outputs SHALL be registered.
REQ-019 On each advancing edge, cphi2 SHALL be set to 1 if the next ph >= NLOW, else 0.
REQ-020 vphi2 SHALL be set to 1 if the next ph is in [NLOW+VSHIFT, NMC-1] or in [0, VSHIFT-1], else 0.
REQ-021 At ph = NLOW-2: if run=0, ph SHALL hold and stopped SHALL be 1 on each such edge; if run=1, ph SHALL advance and setup_cs SHALL pulse.
REQ-022 At ph = NMC-2: if stretch=1 and waitcnt < MAXWAIT, ph SHALL hold, waitcnt SHALL increment, and cphi2/vphi2 SHALL hold.
REQ-023 At ph = NMC-2: if stretch=0, or waitcnt = MAXWAIT, ph SHALL advance and release_wr SHALL pulse; stretch_to SHALL pulse only when this exit was forced with stretch=1.
REQ-024 waitcnt SHALL clear when ph leaves NMC-2.
REQ-025 On leaving ph = NMC-1, release_cs SHALL pulse and cycle_cnt SHALL increment, wrapping modulo 2^CCW.
REQ-026 setup_cs, release_wr, release_cs, stretch_to and stopped SHALL default to 0 on every edge where not explicitly set.
REQ-027 run SHALL be sampled only at ph = NLOW-2; stretch SHALL be sampled only at ph = NMC-2; both are ignored elsewhere.
REQ-028 Deasserting run mid-cycle SHALL NOT truncate the cycle; the halt occurs at the next ph = NLOW-2.
REQ-029 With default parameters, the waveform SHALL be identical to the existing six-microcycle phasing.

Reset
REQ-030 While reset=1: ph=0, waitcnt=0, cycle_cnt=0, cphi2=0, all pulse outputs 0, stopped=0.
REQ-031 While reset=1, vphi2 SHALL take the REQ-020 value for ph=0 (1 when VSHIFT>=1).
REQ-032 Reset asserted mid-stretch or mid-stop SHALL take effect on the next edge, with no pulse emitted.

Structure
REQ-033 Phase-index constants (SETUP_PH=NLOW-2, RELWR_PH=NMC-2, RELCS_PH=NMC-1) and the parameter legality checks SHALL live in package phaser_pkg.
REQ-034 The block SHALL be a single module with no sub-modules; elaboration SHALL fail on illegal parameters.

Verification
REQ-035 Defaults, run=1, stretch=0, 12 clocks -> cphi2 period 6 with 3 low / 3 high; vphi2 rises 1 clock after cphi2; setup_cs, release_wr and release_cs each pulse once per cycle; cycle_cnt=2.
REQ-036 Defaults, run=0 from reset -> stopped=1 continuously from clock 2; cphi2=0; no setup_cs. Then run=1 -> setup_cs on the next edge, cphi2 rises 1 clock later.
REQ-037 Defaults, stretch=1 for 4 clocks at ph=4 -> cphi2 high for 7 clocks; release_wr delayed 4 clocks; stretch_to=0.
REQ-038 MAXWAIT=3, stretch held at 1 -> exactly 3 hold cycles, then stretch_to and release_wr pulse together; the next cycle stretches again.
REQ-039 NMC=8, NLOW=4, VSHIFT=2 -> cphi2 4 low / 4 high; vphi2 high for ph in {6,7,0,1}; CCW=4 -> cycle_cnt wraps from 15 to 0.
REQ-040 Reset asserted at ph=4 during a stretch -> next edge gives ph=0, cphi2=0, vphi2=1, cycle_cnt=0, and no pulses.

Source files
------------

// File: rtl/phaser_pkg.sv
// Shared phase-index helpers and parameter legality checks for the 65C02/65C22 phase generator.
package phaser_pkg;

  localparam int unsigned WAITW = 8;

  function automatic int unsigned setup_ph(input int unsigned nlow);
    return nlow - 2;
  endfunction

  function automatic int unsigned relwr_ph(input int unsigned nmc);
    return nmc - 2;
  endfunction

  function automatic int unsigned relcs_ph(input int unsigned nmc);
    return nmc - 1;
  endfunction

  // vphi2 is cphi2 delayed by vshift microcycles, wrapping across the cycle boundary
  function automatic logic vphi2_at(input int unsigned ph, input int unsigned nmc,
                                    input int unsigned nlow, input int unsigned vshift);
    return ((ph >= nlow + vshift) && (ph < nmc)) || (ph < vshift);
  endfunction

  function automatic bit params_legal(input int unsigned nmc, input int unsigned nlow,
                                      input int unsigned vshift, input int unsigned maxwait,
                                      input int unsigned ccw);
    return (nmc >= 4) && (nmc <= 16) &&
           (nlow >= 2) && (nlow <= nmc - 2) &&
           (vshift + 1 <= nlow) &&
           (maxwait >= 1) && (maxwait <= 255) &&
           (ccw >= 1);
  endfunction

endpackage

// File: rtl/phaser_gen_if.sv
// CPU-side control and timing-strobe bundle of the phase generator.
interface phaser_gen_if #(
  parameter int unsigned CCW = 16
);
  logic           run;
  logic           stretch;
  logic           stopped;
  logic           cphi2;
  logic           vphi2;
  logic           setup_cs;
  logic           release_wr;
  logic           release_cs;
  logic           stretch_to;
  logic [CCW-1:0] cycle_cnt;

  modport master (
    output run, stretch,
    input  stopped, cphi2, vphi2, setup_cs, release_wr, release_cs, stretch_to, cycle_cnt
  );

  modport slave (
    input  run, stretch,
    output stopped, cphi2, vphi2, setup_cs, release_wr, release_cs, stretch_to, cycle_cnt
  );
endinterface

// File: rtl/phaser_gen.sv
// Microcycle phase generator: derives cphi2/vphi2 and bus strobes from clk6x,
// with run/stop at the low phase and bounded stretching of the high phase.
module phaser_gen
  import phaser_pkg::*;
#(
  parameter int unsigned NMC     = 6,
  parameter int unsigned NLOW    = 3,
  parameter int unsigned VSHIFT  = 1,
  parameter int unsigned MAXWAIT = 15,
  parameter int unsigned CCW     = 16
) (
  input  logic         clk6x,
  input  logic         reset,
  phaser_gen_if.slave  bus
);

  localparam int unsigned PHW = $clog2(NMC);

  localparam logic [PHW-1:0]   SETUP_PH = PHW'(setup_ph(NLOW));
  localparam logic [PHW-1:0]   RELWR_PH = PHW'(relwr_ph(NMC));
  localparam logic [PHW-1:0]   RELCS_PH = PHW'(relcs_ph(NMC));
  localparam logic [PHW-1:0]   LOW_END  = PHW'(NLOW);
  localparam logic [WAITW-1:0] WAIT_MAX = WAITW'(MAXWAIT);
  localparam logic             VPHI2_RST = vphi2_at(0, NMC, NLOW, VSHIFT);

  generate
    if (!params_legal(NMC, NLOW, VSHIFT, MAXWAIT, CCW)) begin : g_illegal
      $error("phaser_gen: illegal parameter combination");
    end
  endgenerate

  logic [PHW-1:0]   ph,      ph_n;
  logic [WAITW-1:0] waitcnt, waitcnt_n;
  logic [CCW-1:0]   cnt,     cnt_n;
  logic cphi2,      cphi2_n;
  logic vphi2,      vphi2_n;
  logic setup_cs,   setup_cs_n;
  logic release_wr, release_wr_n;
  logic release_cs, release_cs_n;
  logic stretch_to, stretch_to_n;
  logic stopped,    stopped_n;

  // Next phase and strobes; run and stretch only matter at their own phase
  always_comb begin
    ph_n         = ph;
    waitcnt_n    = waitcnt;
    cnt_n        = cnt;
    setup_cs_n   = 1'b0;
    release_wr_n = 1'b0;
    release_cs_n = 1'b0;
    stretch_to_n = 1'b0;
    stopped_n    = 1'b0;

    if (ph == SETUP_PH) begin
      if (bus.run) begin
        ph_n       = ph + PHW'(1);
        setup_cs_n = 1'b1;
      end else begin
        stopped_n  = 1'b1;
      end
    end else if (ph == RELWR_PH) begin
      if (bus.stretch && (waitcnt < WAIT_MAX)) begin
        waitcnt_n    = waitcnt + WAITW'(1);
      end else begin
        ph_n         = ph + PHW'(1);
        waitcnt_n    = '0;
        release_wr_n = 1'b1;
        stretch_to_n = bus.stretch;
      end
    end else if (ph == RELCS_PH) begin
      ph_n         = '0;
      release_cs_n = 1'b1;
      cnt_n        = cnt + CCW'(1);
    end else begin
      ph_n = ph + PHW'(1);
    end

    // Clocks follow the phase being entered, so a hold keeps them steady
    cphi2_n = (ph_n >= LOW_END);
    vphi2_n = vphi2_at(32'(ph_n), NMC, NLOW, VSHIFT);
  end

  always_ff @(posedge clk6x) begin
    if (reset) begin
      ph         <= '0;
      waitcnt    <= '0;
      cnt        <= '0;
      cphi2      <= 1'b0;
      vphi2      <= VPHI2_RST;
      setup_cs   <= 1'b0;
      release_wr <= 1'b0;
      release_cs <= 1'b0;
      stretch_to <= 1'b0;
      stopped    <= 1'b0;
    end else begin
      ph         <= ph_n;
      waitcnt    <= waitcnt_n;
      cnt        <= cnt_n;
      cphi2      <= cphi2_n;
      vphi2      <= vphi2_n;
      setup_cs   <= setup_cs_n;
      release_wr <= release_wr_n;
      release_cs <= release_cs_n;
      stretch_to <= stretch_to_n;
      stopped    <= stopped_n;
    end
  end

  assign bus.cphi2      = cphi2;
  assign bus.vphi2      = vphi2;
  assign bus.setup_cs   = setup_cs;
  assign bus.release_wr = release_wr;
  assign bus.release_cs = release_cs;
  assign bus.stretch_to = stretch_to;
  assign bus.stopped    = stopped;
  assign bus.cycle_cnt  = cnt;

endmodule

// File: tb/tb_phaser_gen.sv
// Scoreboard bench for phaser_gen: default, MAXWAIT=3 and 8-microcycle instances.
module tb_phaser_gen;

  typedef struct packed {
    logic        cphi2;
    logic        vphi2;
    logic        setup_cs;
    logic        release_wr;
    logic        release_cs;
    logic        stretch_to;
    logic        stopped;
    logic [15:0] cnt;
  } sig_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   fails = 0;
  sig_t exp_q[$];

  always #5 clk = ~clk;

  phaser_gen_if #(.CCW(16)) if0 ();
  phaser_gen_if #(.CCW(16)) if1 ();
  phaser_gen_if #(.CCW(4))  if2 ();

  phaser_gen u_def (.clk6x(clk), .reset(reset), .bus(if0));
  phaser_gen #(.MAXWAIT(3)) u_mw (.clk6x(clk), .reset(reset), .bus(if1));
  phaser_gen #(.NMC(8), .NLOW(4), .VSHIFT(2), .CCW(4)) u_p8 (.clk6x(clk), .reset(reset), .bus(if2));

  // Expected outputs after entering phase nph
  function automatic sig_t mk(input int nmc, input int nlow, input int vshift, input int nph,
                              input bit su, input bit wr, input bit cs, input bit to,
                              input bit st, input int cnt);
    sig_t m;
    m.cphi2      = (nph >= nlow);
    m.vphi2      = ((nph >= nlow + vshift) && (nph <= nmc - 1)) || (nph < vshift);
    m.setup_cs   = su;
    m.release_wr = wr;
    m.release_cs = cs;
    m.stretch_to = to;
    m.stopped    = st;
    m.cnt        = 16'(cnt);
    return m;
  endfunction

  function automatic sig_t get_obs(input int sel);
    sig_t o;
    case (sel)
      0:       o = '{if0.cphi2, if0.vphi2, if0.setup_cs, if0.release_wr, if0.release_cs,
                     if0.stretch_to, if0.stopped, if0.cycle_cnt};
      1:       o = '{if1.cphi2, if1.vphi2, if1.setup_cs, if1.release_wr, if1.release_cs,
                     if1.stretch_to, if1.stopped, if1.cycle_cnt};
      default: o = '{if2.cphi2, if2.vphi2, if2.setup_cs, if2.release_wr, if2.release_cs,
                     if2.stretch_to, if2.stopped, 16'(if2.cycle_cnt)};
    endcase
    return o;
  endfunction

  task automatic drive(input int sel, input logic r, input logic s);
    case (sel)
      0:       begin if0.run = r; if0.stretch = s; end
      1:       begin if1.run = r; if1.stretch = s; end
      default: begin if2.run = r; if2.stretch = s; end
    endcase
  endtask

  task automatic test_reset(input int sel, input int nmc, input int nlow, input int vshift,
                            input logic r, input logic s);
    sig_t e, o;
    drive(sel, r, s);
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(mk(nmc, nlow, vshift, 0, 0, 0, 0, 0, 0, 0));
      @(posedge clk); #1;
      o = get_obs(sel);
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL reset sel=%0d k=%0d got=%h exp=%h", sel, k, o, e);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_nominal();
    sig_t e, o;
    int nph;
    test_reset(0, 6, 3, 1, 1'b1, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      nph = k % 6;
      exp_q.push_back(mk(6, 3, 1, nph, nph == 2, nph == 5, nph == 0, 0, 0, k / 6));
      @(posedge clk); #1;
      o = get_obs(0);
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL nominal k=%0d got=%h exp=%h", k, o, e);
      end
    end
  endtask

  task automatic test_stop();
    sig_t e, o;
    int nph_tab[13] = '{1, 1, 1, 1, 1, 1, 2, 3, 4, 5, 0, 1, 1};
    test_reset(0, 6, 3, 1, 1'b0, 1'b0);
    for (int k = 1; k <= 13; k++) begin
      drive(0, (k == 7 || k == 8), 1'b0);
      exp_q.push_back(mk(6, 3, 1, nph_tab[k-1], k == 7, k == 10, k == 11, 0,
                         (k >= 2 && k <= 6) || k == 13, (k >= 11) ? 1 : 0));
      @(posedge clk); #1;
      o = get_obs(0);
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL stop k=%0d got=%h exp=%h", k, o, e);
      end
    end
  endtask

  task automatic test_stretch();
    sig_t e, o;
    int nph_tab[10] = '{1, 2, 3, 4, 4, 4, 4, 4, 5, 0};
    int high = 0;
    test_reset(0, 6, 3, 1, 1'b1, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      drive(0, 1'b1, k <= 8);
      exp_q.push_back(mk(6, 3, 1, nph_tab[k-1], k == 2, k == 9, k == 10, 0, 0,
                         (k >= 10) ? 1 : 0));
      @(posedge clk); #1;
      o = get_obs(0);
      if (o.cphi2) high++;
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL stretch k=%0d got=%h exp=%h", k, o, e);
      end
    end
    checks++;
    if (high != 7) begin
      fails++;
      $display("FAIL stretch_high got=%0d exp=7", high);
    end
  endtask

  task automatic test_maxwait();
    sig_t e, o;
    int nph_tab[17] = '{1, 2, 3, 4, 4, 4, 4, 5, 0, 1, 2, 3, 4, 4, 4, 4, 5};
    test_reset(1, 6, 3, 1, 1'b1, 1'b1);
    for (int k = 1; k <= 17; k++) begin
      exp_q.push_back(mk(6, 3, 1, nph_tab[k-1], k == 2 || k == 11, k == 8 || k == 17,
                         k == 9, k == 8 || k == 17, 0, (k >= 9) ? 1 : 0));
      @(posedge clk); #1;
      o = get_obs(1);
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL maxwait k=%0d got=%h exp=%h", k, o, e);
      end
    end
  endtask

  task automatic test_nmc8_wrap();
    sig_t e, o;
    int nph;
    test_reset(2, 8, 4, 2, 1'b1, 1'b0);
    for (int k = 1; k <= 130; k++) begin
      nph = k % 8;
      exp_q.push_back(mk(8, 4, 2, nph, nph == 3, nph == 7, nph == 0, 0, 0, (k / 8) % 16));
      @(posedge clk); #1;
      o = get_obs(2);
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL nmc8 k=%0d got=%h exp=%h", k, o, e);
      end
    end
  endtask

  task automatic test_reset_mid_stretch();
    sig_t e, o;
    int nph_tab[14] = '{1, 2, 3, 4, 5, 0, 1, 2, 3, 4, 4, 4, 0, 1};
    test_reset(0, 6, 3, 1, 1'b1, 1'b0);
    for (int k = 1; k <= 14; k++) begin
      drive(0, 1'b1, k >= 11 && k <= 13);
      reset = (k == 13);
      if (k == 13)
        exp_q.push_back(mk(6, 3, 1, 0, 0, 0, 0, 0, 0, 0));
      else
        exp_q.push_back(mk(6, 3, 1, nph_tab[k-1], k == 2 || k == 8, k == 5, k == 6, 0, 0,
                           (k >= 6 && k <= 12) ? 1 : 0));
      @(posedge clk); #1;
      o = get_obs(0);
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL reset_mid_stretch k=%0d got=%h exp=%h", k, o, e);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    drive(0, 1'b1, 1'b0);
    drive(1, 1'b1, 1'b0);
    drive(2, 1'b1, 1'b0);
    test_nominal();
    test_stop();
    test_stretch();
    test_maxwait();
    test_nmc8_wrap();
    test_reset_mid_stretch();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
